i2sout: RTL and testbench
=========================

Name: i2sout

Overview:
- I2S transmitter. It is the master-side counterpart of the team's I2S receiver: it generates ws and serialises signed PCM samples onto sd, MSB first.
- The mixer core pushes samples through a valid/ready port tagged with a channel. One holding register per channel decouples the core from bus timing.
- Runs entirely in the sck domain.

Parameters:
BITS_PRECISION, 24, sample width in bits; MSB = BITS_PRECISION-1.
SLOT_BITS, 32, sck cycles per channel slot; legal range BITS_PRECISION..64. A frame is 2*SLOT_BITS sck cycles.

Ports:
sck  input  1  bit clock; all logic on rising edge.
rstn  input  1  asynchronous, active-low reset.
data_out  input  BITS_PRECISION  sample from the core, two's complement.
data_left_rightn  input  1  channel tag of data_out: 1 = left, 0 = right.
data_valid  input  1  data_out/data_left_rightn valid.
data_ready  output  1  holding register for the tagged channel is empty.
ws  output  1  word select: 1 = left slot, 0 = right slot. Registered.
sd  output  1  serial data. Registered.
underrun  output  1  one-cycle pulse: a slot started with no sample for its channel.

Behaviour:
- Reset (rstn low, asynchronous):
  - ws=0, sd=0, underrun=0.
  - Slot counter cnt=SLOT_BITS-1.
  - Both holding registers empty, so data_ready=1.
  - Shift register cleared.
- cnt runs 0..SLOT_BITS-1 and wraps to 0. On every edge where cnt wraps to 0, ws toggles.
  - The first edge after reset release therefore gives cnt=0, ws=1, starting with a left slot.
- Waveform per slot, numbered by cnt value during the cycle:
  - cnt=0: sd = the bit shifted out of the previous slot. This is the previous LSB when SLOT_BITS==BITS_PRECISION; otherwise it is 0.
  - cnt=1..BITS_PRECISION: sd = sample bits MSB..LSB. The MSB appears one sck after the ws change, per standard I2S.
  - Remaining cycles: sd=0.
- Load:
  - On the edge producing cnt=0, the holding register of the new channel (ws value after toggle) moves into the shift register and is marked empty.
  - If that register is empty, zeros are loaded and underrun=1 for exactly that one cycle. The slot is still transmitted, as silence.
- Handshake:
  - data_ready = NOT full[data_left_rightn]. This is combinational from the tag and the full flags.
  - A transfer occurs on a rising edge with data_valid && data_ready. It writes the tagged holding register and sets its full flag.
  - The core may hold data_valid with a tag whose register is full; nothing happens until that channel is consumed.
  - data_ready for that channel rises the cycle after consumption.
- Simultaneous events:
  - A write to one channel in the same edge that the other channel is consumed: both take effect.
  - A write to the channel being consumed is impossible, because ready=0 while full.
- Latency: a sample accepted at least one edge before its slot's cnt=0 edge appears MSB-first starting at that slot's cnt=1. Otherwise it waits one full frame.
- Reset mid-slot:
  - Outputs go immediately to reset values and pending samples are discarded.
  - After release, transmission restarts with a complete left slot.
- Arithmetic: no sign extension or rounding. Exactly BITS_PRECISION bits are sent and padding is zero.

Test Plan:
- Reset release, no data, SLOT_BITS=32, BITS_PRECISION=24 -> ws=1 for 32 cycles then 0 for 32, sd all 0. underrun pulses at cnt=0 of every slot (first at the first edge after release).
- Preload left=24'hA5F00F and right=24'h123456, then run one frame -> sd bits 1..24 of the left slot read A5F00F MSB first, then 0s; right slot reads 123456. No underrun.
- SLOT_BITS=BITS_PRECISION=24, left=24'h000001 -> LSB 1 appears on sd during cnt=0 of the following right slot, concurrent with ws=0.
- Loopback into the team's I2S receiver (sampling on falling sck), feeding alternating L/R sequence 24'h800000, 24'h7FFFFF, 24'h000001 -> receiver yields the identical values with matching left_rightn. No underrun.
- Hold data_valid with tag=left while left is full -> data_ready=0 until the cycle after the left slot's cnt=0 edge, then 1; exactly one transfer per slot.
- Assert rstn low at cnt=10 of a right slot with both registers full -> immediate ws=0, sd=0, data_ready=1. After release, a full left slot of zeros is sent with an underrun pulse.

Source files
------------

// File: rtl/i2sout.sv
// I2S master transmitter: generates ws and shifts signed PCM samples onto sd MSB first,
// with one holding register per channel fed from a valid/ready port.
module i2sout #(
  parameter int BITS_PRECISION = 24,
  parameter int SLOT_BITS      = 32
) (
  input  logic                      sck,
  input  logic                      rstn,
  input  logic [BITS_PRECISION-1:0] data_out,
  input  logic                      data_left_rightn,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic                      ws,
  output logic                      sd,
  output logic                      underrun
);

  localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [BITS_PRECISION-1:0] ZERO_WORD = {BITS_PRECISION{1'b0}};

  logic [CW-1:0]             cnt;
  logic [BITS_PRECISION-1:0] hold_l;
  logic [BITS_PRECISION-1:0] hold_r;
  logic [BITS_PRECISION-1:0] shreg;
  logic                      full_l;
  logic                      full_r;

  logic                      wrap;
  logic                      new_ws;
  logic                      new_full;
  logic                      wr_l;
  logic                      wr_r;
  logic                      take_l;
  logic                      take_r;
  logic [BITS_PRECISION-1:0] load_val;

  // Slot boundary detection, handshake and selection of the word for the next slot
  always_comb begin
    wrap       = (cnt == CNT_LAST);
    new_ws     = ~ws;
    data_ready = data_left_rightn ? ~full_l : ~full_r;
    wr_l       = data_valid & data_left_rightn & ~full_l;
    wr_r       = data_valid & ~data_left_rightn & ~full_r;
    take_l     = wrap & new_ws;
    take_r     = wrap & ~new_ws;
    if (new_ws) begin
      new_full = full_l;
      load_val = full_l ? hold_l : ZERO_WORD;
    end else begin
      new_full = full_r;
      load_val = full_r ? hold_r : ZERO_WORD;
    end
  end

  // Slot counter, word select and serialiser; sd lags the shift register by one
  // sck so the MSB lands one cycle after the ws transition
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      cnt      <= CNT_LAST;
      ws       <= 1'b0;
      sd       <= 1'b0;
      underrun <= 1'b0;
      shreg    <= ZERO_WORD;
    end else begin
      sd <= shreg[BITS_PRECISION-1];
      if (wrap) begin
        cnt      <= {CW{1'b0}};
        ws       <= new_ws;
        shreg    <= load_val;
        underrun <= ~new_full;
      end else begin
        cnt      <= cnt + CW'(1);
        shreg    <= shreg << 1;
        underrun <= 1'b0;
      end
    end
  end

  // Left holding register: a write cannot coincide with its own consumption
  // while full, and a write into an empty register being consumed wins
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      hold_l <= ZERO_WORD;
      full_l <= 1'b0;
    end else if (wr_l) begin
      hold_l <= data_out;
      full_l <= 1'b1;
    end else if (take_l) begin
      full_l <= 1'b0;
    end else begin
      full_l <= full_l;
    end
  end

  // Right holding register
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      hold_r <= ZERO_WORD;
      full_r <= 1'b0;
    end else if (wr_r) begin
      hold_r <= data_out;
      full_r <= 1'b1;
    end else if (take_r) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

endmodule

// File: tb/tb_i2sout.sv
// Scoreboard bench for i2sout: a 24/32 instance and a 24/24 instance, each decoded by
// a negedge I2S receiver model that compares every completed slot against a queue.
`timescale 1ns/1ps
module tb_i2sout;
  localparam int BP = 24;

  typedef struct packed {
    logic          lr;
    logic [BP-1:0] data;
    logic          ur;
  } slot_t;

  logic sck = 1'b0;
  logic rstn = 1'b0;
  logic rst1 = 1'b0;
  logic          v[2];
  logic          tg[2];
  logic [BP-1:0] dt[2];
  logic          rdy[2];
  logic          wsv[2];
  logic          sdv[2];
  logic          urv[2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  slot_t q0[$];
  slot_t q1[$];

  bit            act[2];
  logic          pws[2];
  logic [BP-1:0] sh[2];
  int            coll[2];
  int            len[2];
  logic          lrs[2];
  logic          urs[2];
  bit            padok[2];
  int            slen[2] = '{32, 24};

  i2sout #(.BITS_PRECISION(BP), .SLOT_BITS(32)) dut0 (
    .sck(sck), .rstn(rstn), .data_out(dt[0]), .data_left_rightn(tg[0]),
    .data_valid(v[0]), .data_ready(rdy[0]), .ws(wsv[0]), .sd(sdv[0]), .underrun(urv[0])
  );

  i2sout #(.BITS_PRECISION(BP), .SLOT_BITS(24)) dut1 (
    .sck(sck), .rstn(rst1), .data_out(dt[1]), .data_left_rightn(tg[1]),
    .data_valid(v[1]), .data_ready(rdy[1]), .ws(wsv[1]), .sd(sdv[1]), .underrun(urv[1])
  );

  always #5 sck = ~sck;

  always @(posedge sck or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input int k, input logic lr, input logic [BP-1:0] d, input logic ur);
    slot_t e;
    e.lr = lr;
    e.data = d;
    e.ur = ur;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic finalize(input int k);
    slot_t e;
    bit got;
    got = 0;
    if (k == 0 && q0.size() > 0) begin
      e = q0.pop_front();
      got = 1;
    end else if (k == 1 && q1.size() > 0) begin
      e = q1.pop_front();
      got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL slot%0d unexpected: got lr=%0b data=%h ur=%0b", k, lrs[k], sh[k], urs[k]);
    end else if (lrs[k] !== e.lr || sh[k] !== e.data || urs[k] !== e.ur || !padok[k]
                 || coll[k] != BP || len[k] != slen[k]) begin
      bad++;
      $display("FAIL slot%0d: got lr=%0b data=%h ur=%0b padok=%0b bits=%0d len=%0d expected lr=%0b data=%h ur=%0b padok=1 bits=%0d len=%0d",
               k, lrs[k], sh[k], urs[k], padok[k], coll[k], len[k], e.lr, e.data, e.ur, BP, slen[k]);
    end
  endtask

  // Receiver model: samples on falling sck, a ws change marks a slot start
  always @(negedge sck) begin
    for (int k = 0; k < 2; k++) begin
      if (!((k == 0) ? rstn : rst1)) begin
        act[k] = 0;
        pws[k] = 1'b0;
      end else if (wsv[k] !== pws[k]) begin
        if (act[k]) begin
          if (coll[k] < BP) begin
            sh[k] = {sh[k][BP-2:0], sdv[k]};
            coll[k]++;
          end else if (sdv[k] !== 1'b0) begin
            padok[k] = 0;
          end
          finalize(k);
        end
        act[k] = 1;
        pws[k] = wsv[k];
        lrs[k] = wsv[k];
        urs[k] = urv[k];
        coll[k] = 0;
        len[k] = 1;
        padok[k] = 1;
        sh[k] = '0;
      end else if (act[k]) begin
        len[k]++;
        if (urv[k] !== 1'b0) padok[k] = 0;
        if (coll[k] < BP) begin
          sh[k] = {sh[k][BP-2:0], sdv[k]};
          coll[k]++;
        end else if (sdv[k] !== 1'b0) begin
          padok[k] = 0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 5000) begin
      @(negedge sck);
      g++;
    end
    if (cyc < n) chk("wait_cyc_timeout", cyc, n);
  endtask

  task automatic send(input int k, input logic lr, input logic [BP-1:0] d, output int acc);
    int g = 0;
    @(negedge sck);
    v[k] = 1'b1;
    tg[k] = lr;
    dt[k] = d;
    #1;
    while (!rdy[k] && g < 1000) begin
      @(negedge sck);
      #1;
      g++;
    end
    if (!rdy[k]) begin
      chk("send_timeout", 32'(rdy[k]), 32'd1);
      v[k] = 1'b0;
      acc = -1;
    end else begin
      @(posedge sck);
      #1;
      acc = cyc;
      v[k] = 1'b0;
    end
  endtask

  initial begin
    int a0;
    int a1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0;
      tg[k] = 1'b1;
      dt[k] = '0;
    end
    repeat (3) @(negedge sck);
    #1;
    chk("rst_ws", 32'(wsv[0]), 32'd0);
    chk("rst_sd", 32'(sdv[0]), 32'd0);
    chk("rst_ur", 32'(urv[0]), 32'd0);
    chk("rst_rdy_l", 32'(rdy[0]), 32'd1);
    tg[0] = 1'b0;
    #1;
    chk("rst_rdy_r", 32'(rdy[0]), 32'd1);

    push(0, 1'b1, 24'h000000, 1'b1);
    push(0, 1'b0, 24'h123456, 1'b0);
    push(0, 1'b1, 24'hA5F00F, 1'b0);
    push(0, 1'b0, 24'h000000, 1'b1);
    push(0, 1'b1, 24'h800000, 1'b0);
    push(0, 1'b0, 24'h7FFFFF, 1'b0);
    push(0, 1'b1, 24'h000001, 1'b0);
    push(1, 1'b1, 24'h000000, 1'b1);
    push(1, 1'b0, 24'h000000, 1'b1);
    push(1, 1'b1, 24'h000001, 1'b0);
    push(1, 1'b0, 24'h000000, 1'b1);

    @(negedge sck);
    #2;
    rstn = 1'b1;
    rst1 = 1'b1;

    fork
      begin
        send(0, 1'b1, 24'hA5F00F, a0);
        send(0, 1'b0, 24'h123456, a0);
        wait_cyc(66);
        send(0, 1'b1, 24'h800000, a0);
        send(0, 1'b1, 24'h000001, a0);
        chk("hold_accept_cycle", a0, 130);
        send(0, 1'b0, 24'h7FFFFF, a0);
        wait_cyc(226);
        send(0, 1'b1, 24'h111111, a0);
        send(0, 1'b0, 24'h222222, a0);
        wait_cyc(235);
        tg[0] = 1'b1;
        #1;
        chk("full_rdy_l", 32'(rdy[0]), 32'd0);
        tg[0] = 1'b0;
        #1;
        chk("full_rdy_r", 32'(rdy[0]), 32'd0);
        chk("mid_ws_right", 32'(wsv[0]), 32'd0);
        rstn = 1'b0;
        #1;
        chk("midrst_ws", 32'(wsv[0]), 32'd0);
        chk("midrst_sd", 32'(sdv[0]), 32'd0);
        chk("midrst_ur", 32'(urv[0]), 32'd0);
        chk("midrst_rdy_r", 32'(rdy[0]), 32'd1);
        tg[0] = 1'b1;
        #1;
        chk("midrst_rdy_l", 32'(rdy[0]), 32'd1);
      end
      begin
        send(1, 1'b1, 24'h000001, a1);
        wait_cyc(73);
        chk("d1_lsb_at_cnt0", {30'd0, wsv[1], sdv[1]}, 32'd1);
        wait_cyc(100);
        #2;
        rst1 = 1'b0;
      end
    join

    push(0, 1'b1, 24'h000000, 1'b1);
    push(0, 1'b0, 24'h000000, 1'b1);
    repeat (3) @(negedge sck);
    #2;
    rstn = 1'b1;
    wait_cyc(70);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
